// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_e : FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   clog2() : ceiling log2, used to size the bit counter (minimum 1 bit)
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Elaboration-time helper. The loop bound keeps it synthesizable and
  // avoids evaluating 1 << 31, which is negative as an int.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for serial_add_ctrl.
//   master : requester side (drives start, sub, A, B, Cin)
//   slave  : controller side (drives ready, busy, done, Sum, Ca, ovf)
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Ca;
  logic             ovf;

  modport master (
    output start, sub, A, B, Cin,
    input  ready, busy, done, Sum, Ca, ovf
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output ready, busy, done, Sum, Ca, ovf
  );
endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full-adder cell shared by every bit position of the serial datapath.
//   A, B, Cin : operand bits and carry-in
//   Sum, Ca   : sum bit and carry-out
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Ca
);
  assign Sum = A ^ B ^ Cin;
  assign Ca  = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell processes the
// operands LSB first, one bit per cycle, with a carry flop between bits.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_add_ctrl_if (start/sub/A/B/Cin in,
//           ready/busy/done/Sum/Ca/ovf out)
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ca_q, ca_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic cell_sum, cell_ca;
  logic accept, last_bit;

  // Start is honoured in DONE as well as IDLE so results can run back-to-back.
  assign accept   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

  full_adder u_cell (
    .A   (op_a_q[0]),
    .B   (op_b_q[0]),
    .Cin (carry_q),
    .Sum (cell_sum),
    .Ca  (cell_ca)
  );

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the default arm pulls the unused encoding back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE:  state_d = bus.start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ready = (state_q == S_IDLE) || (state_q == S_DONE);
    bus.busy  = (state_q == S_RUN);
    bus.done  = (state_q == S_DONE);
  end

  assign bus.Sum = sum_q;
  assign bus.Ca  = ca_q;
  assign bus.ovf = ovf_q;

  // Datapath next-state
  always_comb begin
    // NOTE: every target gets a hold default first so no latch is inferred
    // on paths that do not assign it.
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ca_d    = ca_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and force the carry-in.
      op_a_d  = bus.A;
      op_b_d  = bus.B ^ {WIDTH{bus.sub}};
      carry_d = bus.sub ? 1'b1 : bus.Cin;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      shift_d = {cell_sum, shift_q[WIDTH-1:1]};
      op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
      op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
      carry_d = cell_ca;
      cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
      if (last_bit) begin
        // carry_q is the carry into the MSB during the last bit.
        sum_d = {cell_sum, shift_q[WIDTH-1:1]};
        ca_d  = cell_ca;
        ovf_d = carry_q ^ cell_ca;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      shift_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ca_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ca_q    <= ca_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_add_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_add_ctrl_if #(.WIDTH(13)) bus13 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, carry into MSB from the low W-1 bits.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sb,
                                output logic [31:0] s, output logic ca, output logic ov);
    longint mask, lo_mask, bp, c0, full, lo;
    mask    = (longint'(1) << w) - 1;
    lo_mask = (longint'(1) << (w - 1)) - 1;
    bp      = sb ? (~longint'(b) & mask) : (longint'(b) & mask);
    c0      = sb ? 1 : longint'(cin);
    full    = (longint'(a) & mask) + bp + c0;
    lo      = (longint'(a) & lo_mask) + (bp & lo_mask) + c0;
    s       = 32'(full & mask);
    ca      = 1'((full >> w) & 1);
    ov      = 1'(((lo >> (w - 1)) & 1) ^ ((full >> w) & 1));
  endfunction

  // Issue one operation, scramble the inputs after acceptance, wait for done.
  task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sb,
                        output logic [31:0] s, output logic ca, output logic ov,
                        output int cycles, output bit held, output bit timed_out);
    logic [31:0] prev;
    logic        d;
    prev = wide ? 32'(bus13.Sum) : 32'(bus8.Sum);
    if (wide) begin
      bus13.A = 13'(a); bus13.B = 13'(b); bus13.Cin = cin; bus13.sub = sb; bus13.start = 1'b1;
    end else begin
      bus8.A = 8'(a); bus8.B = 8'(b); bus8.Cin = cin; bus8.sub = sb; bus8.start = 1'b1;
    end
    held = 1'b1; timed_out = 1'b1; cycles = 0;
    s = '0; ca = 1'b0; ov = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (i == 0) begin
        if (wide) begin
          bus13.start = 1'b0; bus13.A = 13'($urandom); bus13.B = 13'($urandom);
          bus13.Cin = 1'($urandom); bus13.sub = 1'($urandom);
        end else begin
          bus8.start = 1'b0; bus8.A = 8'($urandom); bus8.B = 8'($urandom);
          bus8.Cin = 1'($urandom); bus8.sub = 1'($urandom);
        end
      end
      d = wide ? bus13.done : bus8.done;
      if (d) begin
        s  = wide ? 32'(bus13.Sum) : 32'(bus8.Sum);
        ca = wide ? bus13.Ca : bus8.Ca;
        ov = wide ? bus13.ovf : bus8.ovf;
        timed_out = 1'b0;
        break;
      end
      if ((wide ? 32'(bus13.Sum) : 32'(bus8.Sum)) !== prev) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
    bus13.start = 1'b0; bus13.sub = 1'b0; bus13.A = '0; bus13.B = '0; bus13.Cin = 1'b0;
    #3;
    total++; if (bus8.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus8.ready); end
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus8.busy); end
    total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus8.done); end
    total++; if ({bus8.Sum, bus8.Ca, bus8.ovf} !== 10'h0) begin bad++; $display("FAIL reset_result got %h/%b/%b want 00/0/0", bus8.Sum, bus8.Ca, bus8.ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic;
    logic [31:0] s; logic ca, ov; int cyc; bit held, to;
    run_op(1'b0, 32'h5A, 32'h3C, 1'b0, 1'b0, s, ca, ov, cyc, held, to);
    total++; if (to || cyc != 9) begin bad++; $display("FAIL add_latency got %0d want 9", cyc); end
    total++; if (s !== 32'h96) begin bad++; $display("FAIL add_sum got %h want 96", s); end
    total++; if (ca !== 1'b0) begin bad++; $display("FAIL add_ca got %b want 0", ca); end
    total++; if (ov !== 1'b1) begin bad++; $display("FAIL add_ovf got %b want 1", ov); end
  endtask

  task automatic test_carry;
    logic [31:0] s; logic ca, ov; int cyc; bit held, to;
    run_op(1'b0, 32'hFF, 32'h01, 1'b0, 1'b0, s, ca, ov, cyc, held, to);
    total++; if (to || {s, ca, ov} !== {32'h00, 1'b1, 1'b0}) begin bad++; $display("FAIL carry_cin0 got %h/%b/%b want 00/1/0", s, ca, ov); end
    run_op(1'b0, 32'hFF, 32'h01, 1'b1, 1'b0, s, ca, ov, cyc, held, to);
    total++; if (to || {s, ca} !== {32'h01, 1'b1}) begin bad++; $display("FAIL carry_cin1 got %h/%b want 01/1", s, ca); end
  endtask

  task automatic test_sub;
    logic [31:0] s; logic ca, ov; int cyc; bit held, to;
    run_op(1'b0, 32'h10, 32'h20, 1'b1, 1'b1, s, ca, ov, cyc, held, to);
    total++; if (to || {s, ca, ov} !== {32'hF0, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_borrow got %h/%b/%b want f0/0/0", s, ca, ov); end
    run_op(1'b0, 32'h80, 32'h01, 1'b0, 1'b1, s, ca, ov, cyc, held, to);
    total++; if (to || {s, ca, ov} !== {32'h7F, 1'b1, 1'b1}) begin bad++; $display("FAIL sub_ovf got %h/%b/%b want 7f/1/1", s, ca, ov); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] av [4] = '{8'h01, 8'h7F, 8'hAA, 8'hC0};
    logic [7:0] bv [4] = '{8'h02, 8'h01, 8'h55, 8'h40};
    logic [9:0] ev [4] = '{{8'h03, 2'b00}, {8'h80, 2'b01}, {8'hFF, 2'b00}, {8'h00, 2'b10}};
    int k, last;
    k = 0; last = 0;
    bus8.sub = 1'b0; bus8.Cin = 1'b0; bus8.A = av[0]; bus8.B = bv[0]; bus8.start = 1'b1;
    for (int i = 1; i <= 60 && k < 4; i++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        total++; if ({bus8.Sum, bus8.Ca, bus8.ovf} !== ev[k]) begin bad++; $display("FAIL b2b_result%0d got %h want %h", k, {bus8.Sum, bus8.Ca, bus8.ovf}, ev[k]); end
        total++; if (i - last != 9) begin bad++; $display("FAIL b2b_spacing%0d got %0d want 9", k, i - last); end
        last = i;
        k++;
        if (k < 4) begin bus8.A = av[k]; bus8.B = bv[k]; end
        else bus8.start = 1'b0;
      end
    end
    bus8.start = 1'b0;
    total++; if (k != 4) begin bad++; $display("FAIL b2b_count got %0d want 4", k); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    bus8.sub = 1'b0; bus8.Cin = 1'b0; bus8.A = 8'h11; bus8.B = 8'h22; bus8.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      bus8.start = (i == 3) || (i == 5);
      if (bus8.start) begin bus8.A = 8'hFF; bus8.B = 8'hFF; end
      if (bus8.done) dones++;
    end
    total++; if (dones != 1) begin bad++; $display("FAIL ignore_dones got %0d want 1", dones); end
    total++; if (bus8.Sum !== 8'h33) begin bad++; $display("FAIL ignore_sum got %h want 33", bus8.Sum); end
    total++; if (bus8.ready !== 1'b1) begin bad++; $display("FAIL ignore_idle got %b want 1", bus8.ready); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] s; logic ca, ov; int cyc; bit held, to;
    int dones;
    bus8.sub = 1'b0; bus8.Cin = 1'b0; bus8.A = 8'h5A; bus8.B = 8'h3C; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if ({bus8.Sum, bus8.Ca, bus8.ovf} !== 10'h0) begin bad++; $display("FAIL midrst_result got %h/%b/%b want 00/0/0", bus8.Sum, bus8.Ca, bus8.ovf); end
    total++; if ({bus8.ready, bus8.busy, bus8.done} !== 3'b100) begin bad++; $display("FAIL midrst_status got %b want 100", {bus8.ready, bus8.busy, bus8.done}); end
    #2;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL midrst_nodone got %0d want 0", dones); end
    run_op(1'b0, 32'h01, 32'h01, 1'b0, 1'b0, s, ca, ov, cyc, held, to);
    total++; if (to || {s, ca, ov} !== {32'h02, 1'b0, 1'b0}) begin bad++; $display("FAIL midrst_next got %h/%b/%b want 02/0/0", s, ca, ov); end
  endtask

  task automatic test_random(input bit wide, input int n);
    logic [31:0] a, b, s, es; logic cin, sb, ca, ov, eca, eov; int cyc, w; bit held, to;
    w = wide ? 13 : 8;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sb = 1'($urandom);
      model(w, a, b, cin, sb, es, eca, eov);
      run_op(wide, a, b, cin, sb, s, ca, ov, cyc, held, to);
      total++; if (to || cyc != w + 1) begin bad++; $display("FAIL rnd%0d_latency op%0d got %0d want %0d", w, i, cyc, w + 1); end
      total++; if (s !== es) begin bad++; $display("FAIL rnd%0d_sum op%0d got %h want %h", w, i, s, es); end
      total++; if (ca !== eca) begin bad++; $display("FAIL rnd%0d_ca op%0d got %b want %b", w, i, ca, eca); end
      total++; if (ov !== eov) begin bad++; $display("FAIL rnd%0d_ovf op%0d got %b want %b", w, i, ov, eov); end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL rnd%0d_hold op%0d got %b want 1", w, i, held); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_basic();
    test_carry();
    test_sub();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
